// File: rtl/i2c_target_stream_rx.sv
// I2C target write receiver: matches a 7-bit address, ACKs bytes and streams them out.
// Ports: clk/rst_n, en, scl_i/sda_i in, scl_oe/sda_oe drives, tdata/tvalid/tready stream, status.
module i2c_target_stream_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready,
  output logic       start_det,
  output logic       stop_det,
  output logic       addr_match,
  output logic [7:0] byte_cnt
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, HOLD, DATA_ACK, IGNORE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] cnt_inc;
  logic       slot_free;

  // Synchronisers reset to the idle bus level so no edge appears at reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

  assign cnt_inc   = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
  assign slot_free = ~tvalid | tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
      tdata      <= '0;
      tvalid     <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      addr_match <= 1'b0;
      byte_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
    end else begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      // A load later in this block overrides the drop
      if (tvalid && tready) tvalid <= 1'b0;

      if (!en) begin
        state      <= IDLE;
        scl_oe     <= 1'b0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bit_cnt    <= '0;
      end else if (stop) begin
        stop_det   <= 1'b1;
        state      <= IDLE;
        scl_oe     <= 1'b0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bit_cnt    <= '0;
      end else if (start) begin
        start_det  <= 1'b1;
        state      <= ADDR;
        scl_oe     <= 1'b0;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bit_cnt    <= '0;
        byte_cnt   <= '0;
      end else begin
        if (scl_rise && (state == ADDR || state == DATA)
            && bit_cnt != 4'd8) begin
          shreg   <= {shreg[6:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg[7:1] == TARGET_ADDR && !shreg[0]) begin
                sda_oe     <= 1'b1;
                addr_match <= 1'b1;
                state      <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              if (slot_free) begin
                tdata    <= shreg;
                tvalid   <= 1'b1;
                sda_oe   <= 1'b1;
                byte_cnt <= cnt_inc;
                state    <= DATA_ACK;
              end else begin
                scl_oe <= 1'b1;
                state  <= HOLD;
              end
            end
          end
          HOLD: begin
            if (slot_free) begin
              tdata    <= shreg;
              tvalid   <= 1'b1;
              sda_oe   <= 1'b1;
              scl_oe   <= 1'b0;
              byte_cnt <= cnt_inc;
              state    <= DATA_ACK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_stream_rx.sv
// Directed bench for i2c_target_stream_rx: an open-drain I2C controller model
// drives the bus while a monitor records stream handshakes and status pulses.
module tb_i2c_target_stream_rx;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  logic tready = 1'b0;
  logic scl_line, sda_line;
  logic scl_oe, sda_oe, tvalid, start_det, stop_det, addr_match;
  logic [7:0] tdata, byte_cnt;

  int checks = 0;
  int passed = 0;
  int n_start = 0;
  int n_stop = 0;
  logic [7:0] hs[$];

  assign scl_line = scl_drv & ~scl_oe;
  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_stream_rx dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .scl_i(scl_line), .sda_i(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .start_det(start_det), .stop_det(stop_det),
    .addr_match(addr_match), .byte_cnt(byte_cnt)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      if (tvalid && tready) hs.push_back(tdata);
      if (start_det) n_start++;
      if (stop_det) n_stop++;
    end
  end

  task automatic qwait;
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_high;
    int n;
    n = 0;
    scl_drv = 1'b1;
    while (!scl_line && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!scl_line) begin
      checks++;
      $display("FAIL scl_release timeout: scl still low after %0d clk", n);
    end
  endtask

  task automatic bus_start;
    sda_drv = 1'b1; qwait;
    scl_high;       qwait;
    sda_drv = 1'b0; qwait;
    scl_drv = 1'b0; qwait;
  endtask

  task automatic bus_stop;
    sda_drv = 1'b0; qwait;
    scl_high;       qwait;
    sda_drv = 1'b1; qwait;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;    qwait;
    scl_high;       qwait;
    scl_drv = 1'b0; qwait;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_drv = 1'b1; qwait;
    scl_high;
    repeat (3) @(negedge clk);
    ack = ~sda_line;
    qwait;
    scl_drv = 1'b0; qwait;
  endtask

  function automatic logic [23:0] hs_view();
    logic [7:0] a, b;
    a = (hs.size() > 0) ? hs[0] : 8'h00;
    b = (hs.size() > 1) ? hs[1] : 8'h00;
    return {8'(hs.size()), a, b};
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({scl_oe, sda_oe, tdata, tvalid, start_det, stop_det, addr_match, byte_cnt} !== 22'd0)
      $display("FAIL reset_hold: outputs=%h want 0",
        {scl_oe, sda_oe, tdata, tvalid, start_det, stop_det, addr_match, byte_cnt});
    else passed++;
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({scl_oe, sda_oe, tvalid, addr_match, byte_cnt} !== 12'd0)
      $display("FAIL reset_release: outputs=%h want 0",
        {scl_oe, sda_oe, tvalid, addr_match, byte_cnt});
    else passed++;
  endtask

  task automatic test_write;
    logic a0, a1, a2;
    int s0;
    tready = 1'b1;
    hs.delete();
    bus_start;
    send_byte(8'hA0, a0);
    send_byte(8'hA5, a1);
    send_byte(8'h3C, a2);
    s0 = n_stop;
    bus_stop;
    checks++;
    if ({a0, a1, a2} !== 3'b111) $display("FAIL write_acks: got %b want 111", {a0, a1, a2});
    else passed++;
    checks++;
    if (hs_view() !== 24'h02A53C) $display("FAIL write_stream: got %h want 02a53c", hs_view());
    else passed++;
    checks++;
    if (byte_cnt !== 8'd2) $display("FAIL write_byte_cnt: got %0d want 2", byte_cnt);
    else passed++;
    checks++;
    if (n_stop - s0 !== 1) $display("FAIL write_stop_det: got %0d pulses want 1", n_stop - s0);
    else passed++;
    checks++;
    if (addr_match !== 1'b0) $display("FAIL write_match_clear: got %b want 0", addr_match);
    else passed++;
  endtask

  task automatic test_wrong_addr;
    logic a0, a1;
    hs.delete();
    bus_start;
    send_byte(8'hA2, a0);
    send_byte(8'h77, a1);
    checks++;
    if ({a0, a1} !== 2'b00) $display("FAIL wrong_addr_ack: got %b want 00", {a0, a1});
    else passed++;
    checks++;
    if ({tvalid, addr_match, 8'(hs.size())} !== 10'd0)
      $display("FAIL wrong_addr_stream: got %h want 0", {tvalid, addr_match, 8'(hs.size())});
    else passed++;
    bus_stop;
  endtask

  task automatic test_disabled;
    logic a0;
    int s0;
    en = 1'b0;
    s0 = n_start;
    bus_start;
    send_byte(8'hA0, a0);
    checks++;
    if ({a0, addr_match} !== 2'b00 || n_start != s0)
      $display("FAIL disabled: ack=%b match=%b starts=%0d want 0 0 0",
        a0, addr_match, n_start - s0);
    else passed++;
    bus_stop;
    en = 1'b1;
    qwait;
  endtask

  task automatic test_backpressure;
    logic a0, a1, a2;
    tready = 1'b0;
    hs.delete();
    bus_start;
    send_byte(8'hA0, a0);
    send_byte(8'hA5, a1);
    fork
      send_byte(8'h3C, a2);
      begin
        int n;
        n = 0;
        while (!scl_oe && n < 3000) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if ({scl_oe, tvalid, tdata} !== 10'h3A5)
          $display("FAIL bp_hold: scl_oe=%b tvalid=%b tdata=%h want 1 1 a5",
            scl_oe, tvalid, tdata);
        else passed++;
        repeat (50) @(negedge clk);
        checks++;
        if ({scl_oe, scl_line} !== 2'b10)
          $display("FAIL bp_stretch: scl_oe=%b scl=%b want 1 0", scl_oe, scl_line);
        else passed++;
        tready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({tvalid, tdata, sda_oe, scl_oe} !== 11'b1_00111100_1_0)
          $display("FAIL bp_release: tvalid=%b tdata=%h sda_oe=%b scl_oe=%b want 1 3c 1 0",
            tvalid, tdata, sda_oe, scl_oe);
        else passed++;
      end
    join
    bus_stop;
    checks++;
    if ({a0, a1, a2} !== 3'b111) $display("FAIL bp_acks: got %b want 111", {a0, a1, a2});
    else passed++;
    checks++;
    if (hs_view() !== 24'h02A53C || byte_cnt !== 8'd2)
      $display("FAIL bp_stream: got %h cnt=%0d want 02a53c cnt=2", hs_view(), byte_cnt);
    else passed++;
  endtask

  task automatic test_partial_stop;
    logic a0, a1;
    int s0;
    hs.delete();
    bus_start;
    send_byte(8'hA0, a0);
    checks++;
    if ({a0, addr_match} !== 2'b11)
      $display("FAIL partial_addr: ack=%b match=%b want 1 1", a0, addr_match);
    else passed++;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    s0 = n_stop;
    bus_stop;
    checks++;
    if ({tvalid, byte_cnt, addr_match, 8'(hs.size())} !== 18'd0 || n_stop - s0 != 1)
      $display("FAIL partial_stop: tvalid=%b cnt=%0d match=%b bytes=%0d stops=%0d want 0 0 0 0 1",
        tvalid, byte_cnt, addr_match, hs.size(), n_stop - s0);
    else passed++;
    scl_drv = 1'b0;
    qwait;
    send_byte(8'hA0, a1);
    checks++;
    if (a1 !== 1'b0) $display("FAIL idle_no_ack: ack=%b want 0", a1);
    else passed++;
    scl_high;
    qwait;
  endtask

  task automatic test_repeated_start;
    logic a0, a1, a2, a3;
    int s0;
    hs.delete();
    s0 = n_start;
    bus_start;
    send_byte(8'hA0, a0);
    send_byte(8'h11, a1);
    checks++;
    if (byte_cnt !== 8'd1) $display("FAIL rs_first_cnt: got %0d want 1", byte_cnt);
    else passed++;
    bus_start;
    send_byte(8'hA0, a2);
    checks++;
    if (byte_cnt !== 8'd0 || n_start - s0 != 2)
      $display("FAIL rs_restart: cnt=%0d starts=%0d want 0 2", byte_cnt, n_start - s0);
    else passed++;
    send_byte(8'h22, a3);
    checks++;
    if ({a0, a1, a2, a3} !== 4'b1111 || byte_cnt !== 8'd1 || tdata !== 8'h22)
      $display("FAIL rs_second: acks=%b cnt=%0d tdata=%h want 1111 1 22",
        {a0, a1, a2, a3}, byte_cnt, tdata);
    else passed++;
    checks++;
    if (hs_view() !== 24'h021122) $display("FAIL rs_stream: got %h want 021122", hs_view());
    else passed++;
    bus_stop;
  endtask

  task automatic test_async_reset;
    logic a0;
    tready = 1'b0;
    bus_start;
    send_byte(8'hA0, a0);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    checks++;
    if ({sda_oe, tvalid} !== 2'b11)
      $display("FAIL ar_pre: sda_oe=%b tvalid=%b want 1 1", sda_oe, tvalid);
    else passed++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({scl_oe, sda_oe, tdata, tvalid, start_det, stop_det, addr_match, byte_cnt} !== 22'd0)
      $display("FAIL ar_async: outputs=%h want 0",
        {scl_oe, sda_oe, tdata, tvalid, start_det, stop_det, addr_match, byte_cnt});
    else passed++;
    repeat (3) @(negedge clk);
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    qwait;
    rst_n = 1'b1;
    qwait;
  endtask

  initial begin
    test_reset;
    test_write;
    test_wrong_addr;
    test_disabled;
    test_backpressure;
    test_partial_stop;
    test_repeated_start;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
